force_slice_scheduler: RTL and testbench
========================================

# force_slice_scheduler

Sequences force/release commands from several generic-interface requesters onto one shared packed bus. Each requester can force or release a part-select of the bus. The block owns the per-bit force latch, force value and owner registers, and it produces the resolved bus seen by downstream logic. It sits between the per-interface force control and the packed inout port bundle. Round-robin arbitration and ownership checks keep concurrent part-selects from corrupting each other.

## Interface
Parameters:
- `WIDTH`, 8, width of the shared bus.
- `NREQ`, 3, number of requesters.
- `IDW`, derived as $clog2(NREQ), the width of an owner ID.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: command pending, one bit per requester.
- `req_ready` output NREQ: one-cycle accept pulse, one-hot.
- `req_op` input 2*NREQ: per requester; 00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL.
- `req_lsb` input 3*NREQ: low bit of the slice.
- `req_len` input 4*NREQ: slice length, legal range 1..WIDTH.
- `req_val` input WIDTH*NREQ: force value, right-aligned to `req_lsb`.
- `rsp_valid` output NREQ: one-cycle completion pulse.
- `rsp_err` output NREQ: error flag, qualified by `rsp_valid`.
- `bus_in` input WIDTH: the unforced (driven) bus value.
- `bus_out` output WIDTH: the resolved bus value.
- `force_mask` output WIDTH: per-bit forced state.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Bus resolution is combinational: `bus_out[b] = force_mask[b] ? fval[b] : bus_in[b]`. There is no latency from `bus_in`.
- FSM states: IDLE, CHECK, APPLY.
  - IDLE: when any `req_valid` is high, the round-robin arbiter picks a winner and the block pulses `req_ready` to it. It latches that requester's op, lsb, len, val and ID, then moves to CHECK.
  - CHECK: computes slice mask `m = ((1<<len)-1)<<lsb`, truncated to WIDTH, and evaluates the error condition. Moves to APPLY.
  - APPLY: updates the registers when there is no error, registers the response, then returns to IDLE.
- Error conditions:
  - FORCE or RELEASE with `len==0` or `lsb+len>WIDTH`.
  - FORCE where any bit in `m` is forced and owned by a different ID.
  - RELEASE where any bit in `m` is forced and owned by a different ID.
  - On error, no register changes and `rsp_err=1`.
- FORCE: for every bit in `m`, set `force_mask=1`, `fval[b]=req_val[b-lsb]` and owner=ID. Re-forcing bits the requester already owns overwrites their values.
- RELEASE: clears `force_mask` on bits in `m` owned by this ID. Unforced bits inside `m` are legal and unchanged.
- RELEASE_ALL: clears every bit owned by this ID. Slice fields are ignored and it never errors.
- NOP: accepted and acknowledged with `rsp_err=0`; nothing changes.
- Arbitration: round-robin. The pointer starts at requester 0 after reset. After each grant it moves to winner+1 (mod NREQ), so the winner gets lowest priority next.
- Requester obligations:
  - Hold fields stable while `req_valid` is high.
  - Lowering `req_valid` before `req_ready` withdraws the request; nothing happens.
- Reset (any time, including mid-command) clears:
  - the FSM to IDLE and the RR pointer;
  - `force_mask`, `fval` and owners;
  - `req_ready`, `rsp_valid`, `rsp_err` and `busy`.
  
  An in-flight command is dropped with no response.

## Timing
- Accept handshake in cycle T (`req_ready`=1, `busy`=0).
- Cycle T+1 is CHECK and T+2 is APPLY; `busy`=1 in both.
- In cycle T+3, `force_mask`/`bus_out` reflect the command, `rsp_valid` pulses to the issuer, and the FSM is in IDLE. A new command can be accepted in T+3.
- Sustained throughput is one command per 3 cycles.
- `req_ready` and `rsp_valid` are registered, each one-hot at most. A requester can see `rsp_valid` and a new `req_ready` in the same cycle.
- `bus_in` changes appear on unforced `bus_out` bits in the same cycle.

## Structure
- Package `force_sched_pkg` holds:
  - the op enum (`OP_NOP`, `OP_FORCE`, `OP_RELEASE`, `OP_RELEASE_ALL`);
  - the state enum (`S_IDLE`, `S_CHECK`, `S_APPLY`);
  - the lsb/len width constants;
  - the function `slice_mask(lsb,len)` returning WIDTH bits plus an out-of-range flag.
- Sub-module `rr_arbiter` (NREQ-wide; request, advance and grant, with a one-hot grant output) is instantiated once.
- The top level holds the FSM, the command latch and the `force_mask`/`fval`/owner arrays.

## Test plan
- Reset, then req0 FORCE lsb=0 len=4 val=0xA with `bus_in`=0x00: `req_ready`[0] in T, then in T+3 `rsp_valid`[0]=1, `rsp_err`=0, `force_mask`=0x0F, `bus_out`=0x0A. Then req0 RELEASE_ALL gives `force_mask`=0x00 and `bus_out`=`bus_in`.
- With req0 owning [3:0], req1 FORCE lsb=2 len=4 val=0xF: `rsp_err`[1]=1, `force_mask` stays 0x0F. Then req1 FORCE lsb=4 len=4 val=0x5 gives `force_mask`=0xFF and `bus_out`=0x5A.
- All three requesters raise `req_valid` in the same cycle after reset: grants arrive in order 0, 1, 2, each 3 cycles apart. A re-request by 0 during that sequence is served after 2.
- FORCE lsb=6 len=4, and separately len=0: `rsp_err`=1 with no state change. req2 RELEASE lsb=0 len=8 while req0 owns [3:0]: `rsp_err`=1.
- Assert `rst` in CHECK of a FORCE: no `rsp_valid`, `force_mask`=0, `busy`=0. The requester re-issues after reset and completes normally.
- Toggle `bus_in` every cycle with `force_mask`=0xF0: the low nibble of `bus_out` follows `bus_in` in the same cycle and the high nibble stays constant.

Source files
------------

// File: rtl/force_slice_scheduler_pkg.sv
// Shared types for the force/release scheduler: op and state encodings,
// slice field widths and the slice-mask helper.
package force_sched_pkg;

  localparam int LSBW = 3;
  localparam int LENW = 4;

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_FORCE       = 2'b01,
    OP_RELEASE     = 2'b10,
    OP_RELEASE_ALL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_APPLY = 2'b10
  } state_e;

  // Mask is returned un-truncated; callers keep the low bus-width bits.
  typedef struct packed {
    logic        oor;
    logic [31:0] mask;
  } slice_t;

  function automatic slice_t slice_mask(input logic [LSBW-1:0] lsb,
                                        input logic [LENW-1:0] len,
                                        input int width);
    slice_t s;
    s.mask = ((32'd1 << len) - 32'd1) << lsb;
    s.oor  = (len == '0) || ((int'(lsb) + int'(len)) > width);
    return s;
  endfunction

endpackage

// File: rtl/force_slice_scheduler_rr_arbiter.sv
// Round-robin arbiter, combinational one-hot grant from a registered pointer.
// The pointer moves past the accepted requester so it has lowest priority next.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] adv_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;

  // First pass covers requesters at or above the pointer, second pass wraps.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (IDW'(i) >= ptr_q)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (adv_i[i]) ptr_d = (i == NREQ - 1) ? '0 : IDW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/force_slice_scheduler.sv
// Arbitrates force/release part-select commands onto one shared bus; 3 cycles
// per command (accept, check, apply); requesters hold req_valid until req_ready.
module force_slice_scheduler
  import force_sched_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [LSBW*NREQ-1:0]  req_lsb,
  input  logic [LENW*NREQ-1:0]  req_len,
  input  logic [WIDTH*NREQ-1:0] req_val,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ-1:0]       rsp_err,
  input  logic [WIDTH-1:0]      bus_in,
  output logic [WIDTH-1:0]      bus_out,
  output logic [WIDTH-1:0]      force_mask,
  output logic                  busy
);

  state_e                     state_q;
  logic [NREQ-1:0]            ready_q, rsp_valid_q, rsp_err_q, gnt, acc_oh, id_oh;
  op_e                        op_q, sel_op;
  logic [LSBW-1:0]            lsb_q, sel_lsb;
  logic [LENW-1:0]            len_q, sel_len;
  logic [WIDTH-1:0]           val_q, sel_val, shifted;
  logic [IDW-1:0]             id_q, sel_id;
  logic                       err_q, err_d, conflict;
  logic [WIDTH-1:0]           fmask_q, fmask_d, fval_q, fval_d;
  logic [WIDTH-1:0][IDW-1:0]  owner_q, owner_d;
  slice_t                     sm;
  logic                       unused_mask_hi;

  assign acc_oh = (state_q == S_IDLE) ? (ready_q & req_valid) : '0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid),
    .adv_i (acc_oh),
    .gnt_o (gnt)
  );

  always_comb begin
    sel_op  = OP_NOP;
    sel_lsb = '0;
    sel_len = '0;
    sel_val = '0;
    sel_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_oh[i]) begin
        sel_op  = op_e'(req_op[i*2 +: 2]);
        sel_lsb = req_lsb[i*LSBW +: LSBW];
        sel_len = req_len[i*LENW +: LENW];
        sel_val = req_val[i*WIDTH +: WIDTH];
        sel_id  = IDW'(i);
      end
    end
  end

  assign sm             = slice_mask(lsb_q, len_q, WIDTH);
  assign unused_mask_hi = ^sm.mask[31:WIDTH];
  assign shifted        = val_q << lsb_q;
  assign id_oh          = NREQ'(1) << id_q;

  always_comb begin
    conflict = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sm.mask[b] && fmask_q[b] && (owner_q[b] != id_q)) conflict = 1'b1;
    end
    err_d = ((op_q == OP_FORCE) || (op_q == OP_RELEASE)) && (sm.oor || conflict);
  end

  // err_q gates every update, so an errored command leaves all arrays intact.
  always_comb begin
    fmask_d = fmask_q;
    fval_d  = fval_q;
    owner_d = owner_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (!err_q) begin
        case (op_q)
          OP_FORCE: if (sm.mask[b]) begin
            fmask_d[b] = 1'b1;
            fval_d[b]  = shifted[b];
            owner_d[b] = id_q;
          end
          OP_RELEASE:     if (sm.mask[b] && (owner_q[b] == id_q)) fmask_d[b] = 1'b0;
          OP_RELEASE_ALL: if (owner_q[b] == id_q) fmask_d[b] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      op_q        <= OP_NOP;
      lsb_q       <= '0;
      len_q       <= '0;
      val_q       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      fmask_q     <= '0;
      fval_q      <= '0;
      owner_q     <= '0;
    end else begin
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (|acc_oh) begin
            op_q    <= sel_op;
            lsb_q   <= sel_lsb;
            len_q   <= sel_len;
            val_q   <= sel_val;
            id_q    <= sel_id;
            state_q <= S_CHECK;
          end else if (ready_q == '0) begin
            ready_q <= gnt;
          end
        end
        S_CHECK: begin
          err_q   <= err_d;
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          fmask_q     <= fmask_d;
          fval_q      <= fval_d;
          owner_q     <= owner_d;
          rsp_valid_q <= id_oh;
          rsp_err_q   <= err_q ? id_oh : '0;
          ready_q     <= gnt;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign force_mask = fmask_q;
  assign bus_out    = (fmask_q & fval_q) | (~fmask_q & bus_in);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_force_slice_scheduler.sv
// Directed bench for force_slice_scheduler: stimulus pushes expected responses,
// a monitor pops and compares them whenever rsp_valid pulses.
module tb_force_slice_scheduler;

  localparam logic [1:0] NOP = 2'b00, FRC = 2'b01, REL = 2'b10, RALL = 2'b11;

  logic        clk, rst, busy;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err;
  logic [5:0]  req_op;
  logic [8:0]  req_lsb;
  logic [11:0] req_len;
  logic [23:0] req_val;
  logic [7:0]  bus_in, bus_out, force_mask;

  typedef struct {
    int         id;
    bit         err;
    logic [7:0] mask;
    logic [7:0] bus;
  } exp_t;

  exp_t exp_q[$];
  int   rdyq[$];
  int   total = 0, bad = 0, cyc = 0;

  force_slice_scheduler #(.WIDTH(8), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_lsb(req_lsb), .req_len(req_len), .req_val(req_val),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .bus_in(bus_in),
    .bus_out(bus_out), .force_mask(force_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] oh(int id);
    logic [2:0] one;
    one = 3'b001;
    return one << id;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: response checks first, then record any new grant for latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdyq.delete();
      end else begin
        if (rsp_valid != 3'b000) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=0x%0h want none", rsp_valid);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_valid, oh(e.id));
            check("rsp_err", rsp_err, e.err ? oh(e.id) : 3'b000);
            check("rsp_mask", force_mask, e.mask);
            check("rsp_bus", bus_out, e.bus);
            if (rdyq.size() != 0) check("rsp_latency", cyc - rdyq.pop_front(), 3);
          end
        end
        if (req_ready != 3'b000) rdyq.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic set_fields(int r, logic [1:0] op, int lsb, int len, logic [7:0] val);
    req_op[r*2 +: 2]  = op;
    req_lsb[r*3 +: 3] = 3'(lsb);
    req_len[r*4 +: 4] = 4'(len);
    req_val[r*8 +: 8] = val;
  endtask

  task automatic issue(int r, logic [1:0] op, int lsb, int len, logic [7:0] val,
                       bit err, logic [7:0] m, logic [7:0] b);
    bit got = 0;
    exp_q.push_back('{r, err, m, b});
    set_fields(r, op, lsb, len, val);
    req_valid[r] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no req_ready for req%0d want a grant", r);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    drain();
  endtask

  initial begin
    int   order[4] = '{0, 1, 2, 0};
    int   k, drop, prev, id;
    bit   got;
    logic [7:0] pats[6] = '{8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h3C, 8'hC3};

    rst = 1'b1; req_valid = '0; req_op = '0; req_lsb = '0; req_len = '0;
    req_val = '0; bus_in = 8'h96;
    do_reset();
    #1;
    check("reset_mask", force_mask, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", req_ready, 3'b000);
    check("reset_rsp", rsp_valid, 3'b000);
    check("reset_passthru", bus_out, 8'h96);
    bus_in = 8'h00;

    issue(0, FRC, 0, 4, 8'h0A, 0, 8'h0F, 8'h0A);
    issue(0, RALL, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    bus_in = 8'h3C;
    #1 check("released_passthru", bus_out, 8'h3C);
    bus_in = 8'h00;

    issue(0, FRC, 0, 4, 8'h0A, 0, 8'h0F, 8'h0A);
    issue(1, FRC, 2, 4, 8'h0F, 1, 8'h0F, 8'h0A);  // overlaps req0's bits
    issue(1, FRC, 4, 4, 8'h05, 0, 8'hFF, 8'h5A);
    issue(2, FRC, 6, 4, 8'h01, 1, 8'hFF, 8'h5A);  // runs past bit 7
    issue(0, FRC, 0, 0, 8'h01, 1, 8'hFF, 8'h5A);  // zero length
    issue(2, REL, 0, 8, 8'h00, 1, 8'hFF, 8'h5A);
    issue(1, REL, 4, 2, 8'h00, 0, 8'hCF, 8'h4A);
    issue(0, REL, 0, 8, 8'h00, 1, 8'hCF, 8'h4A);
    issue(1, REL, 6, 2, 8'h00, 0, 8'h0F, 8'h0A);
    issue(1, FRC, 4, 4, 8'h0C, 0, 8'hFF, 8'hCA);
    issue(0, RALL, 5, 3, 8'hFF, 0, 8'hF0, 8'hC0);
    issue(2, NOP, 0, 0, 8'h00, 0, 8'hF0, 8'hC0);
    issue(1, FRC, 4, 2, 8'h05, 0, 8'hF0, 8'hD0);  // overwrite own bits, value truncated

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 bus_in = pats[i];
      #1 check("bus_follow", bus_out, {4'hD, pats[i][3:0]});
    end
    bus_in = 8'h00;

    // All three raise valid together; req0 keeps requesting after its grant.
    do_reset();
    req_op = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{order[i], 0, 8'h00, 8'h00});
    req_valid = 3'b111;
    k = 0; drop = -1; prev = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
      if (req_ready != 3'b000) begin
        id = req_ready[0] ? 0 : (req_ready[1] ? 1 : 2);
        check("grant_order", id, order[k]);
        if (k > 0) check("grant_gap", cyc - prev, 3);
        prev = cyc;
        if (k != 0) drop = id;
        k++;
      end
    end
    @(negedge clk);
    if (drop >= 0) req_valid[drop] = 1'b0;
    check("grant_count", k, 4);
    drain();

    // Reset while a FORCE sits in CHECK: command is dropped silently.
    set_fields(2, FRC, 0, 8, 8'hFF);
    req_valid[2] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1;
    end
    check("abort_granted", got, 1'b1);
    @(posedge clk);
    #1 check("abort_busy_check", busy, 1'b1);
    rst = 1'b1;
    req_valid = 3'b000;
    #1;
    check("abort_mask", force_mask, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_rsp", rsp_valid, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_mask_after", force_mask, 8'h00);
    issue(2, FRC, 0, 8, 8'hFF, 0, 8'hFF, 8'hFF);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
